// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-master RAM access arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_arb_pkg;

  // Sequencer states; one command word is issued per ADDR/DATA state
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // RAM command opcodes, carried in ram_din[9:8]
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Requester indices into req/we/done/err and the packed addr/wdata buses
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram_arb_rr2.sv
// ram_arb_rr2: two-way round-robin pick producing a one-hot grant.
// Latency: combinational.
// Backpressure: none; a requester that loses a tie is granted first on the next tie.
module ram_arb_rr2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // A lone requester wins outright; on a tie the one not served last wins
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == REQ_B) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: serialises whole read/write transactions from two masters onto the RAM command stream.
// Latency: write done 3 cycles after req is sampled; read done the cycle after ram_tx_valid (4 with the standard RAM).
// Backpressure: req is held until done; a losing master waits. Build macro RAM_ARB_TIMEOUT_EN bounds read waits.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 15
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req,
  input  logic [1:0]               we,
  input  logic [2*ADDR_SIZE-1:0]   addr,
  input  logic [15:0]              wdata,
  output logic [1:0]               done,
  output logic [1:0]               err,
  output logic [7:0]               rdata,
  output logic [9:0]               ram_din,
  output logic                     ram_rx_valid,
  input  logic [7:0]               ram_dout,
  input  logic                     ram_tx_valid
);

  state_t                 state;
  logic                   gnt_idx;
  logic                   last_grant;
  logic                   lat_we;
  logic [ADDR_SIZE-1:0]   lat_addr;
  logic [7:0]             lat_wdata;
  logic [1:0]             pick;
  logic                   sel_b;
  logic                   sel_we;
  logic [ADDR_SIZE-1:0]   sel_addr;
  logic [7:0]             sel_wdata;

  ram_arb_rr2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (pick)
  );

  // The winning requester's fields, captured only in IDLE
  assign sel_b     = pick[REQ_B];
  assign sel_we    = sel_b ? we[REQ_B] : we[REQ_A];
  assign sel_addr  = sel_b ? addr[2*ADDR_SIZE-1:ADDR_SIZE] : addr[ADDR_SIZE-1:0];
  assign sel_wdata = sel_b ? wdata[15:8] : wdata[7:0];

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          to_hit;
  assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  // No read timeout: err is constant zero (parameter kept referenced so both builds share one interface)
  assign err = (TIMEOUT_CYCLES < 0) ? 2'b11 : 2'b00;
`endif

  // Sequencer: outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gnt_idx      <= REQ_A;
      last_grant   <= REQ_B;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      done         <= 2'b00;
      rdata        <= 8'h00;
      ram_din      <= 10'h000;
      ram_rx_valid <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      err          <= 2'b00;
      to_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_idx      <= sel_b;
            lat_we       <= sel_we;
            lat_addr     <= sel_addr;
            lat_wdata    <= sel_wdata;
            ram_din      <= {(sel_we ? CMD_WR_ADDR : CMD_RD_ADDR), 8'(sel_addr)};
            ram_rx_valid <= 1'b1;
            state        <= ADDR;
          end
        end
        ADDR: begin
          ram_din      <= lat_we ? {CMD_WR_DATA, lat_wdata} : {CMD_RD_DATA, 8'h00};
          ram_rx_valid <= 1'b1;
          state        <= DATA;
        end
        DATA: begin
          ram_din      <= 10'h000;
          ram_rx_valid <= 1'b0;
          if (lat_we) begin
            done  <= gnt_idx ? 2'b10 : 2'b01;
            state <= DONE;
          end else begin
`ifdef RAM_ARB_TIMEOUT_EN
            to_cnt <= '0;
`endif
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Data arriving on the limit cycle still completes normally
          if (ram_tx_valid) begin
            rdata <= ram_dout;
            done  <= gnt_idx ? 2'b10 : 2'b01;
            state <= DONE;
`ifdef RAM_ARB_TIMEOUT_EN
          end else if (to_hit) begin
            rdata <= 8'h00;
            done  <= gnt_idx ? 2'b10 : 2'b01;
            err   <= gnt_idx ? 2'b10 : 2'b01;
            state <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          done       <= 2'b00;
`ifdef RAM_ARB_TIMEOUT_EN
          err        <= 2'b00;
`endif
          last_grant <= gnt_idx;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: randomized two-master traffic against a transaction-level model and a RAM model.
// Latency: checks exact done timing per transaction.
// Backpressure: masters hold req until done and drop it right after.
module tb_ram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [7:0]  rdata;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout = 8'h00;
  logic        ram_tx_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_access_arbiter #(.ADDR_SIZE(8), .TIMEOUT_CYCLES(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
  );

  // RAM model: read data one cycle after the trigger; a write-data command also
  // raises a stray tx_valid with junk data, which the arbiter must ignore
  logic [7:0] mem [256];
  logic [7:0] ram_wa = 8'h00;
  logic [7:0] ram_ra = 8'h00;
  bit         withhold = 1'b0;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    ram_tx_valid <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: ram_wa <= ram_din[7:0];
        2'b01: begin
          mem[ram_wa]  <= ram_din[7:0];
          ram_tx_valid <= 1'b1;
          ram_dout     <= 8'hEE;
        end
        2'b10: ram_ra <= ram_din[7:0];
        default: if (!withhold) begin
          ram_tx_valid <= 1'b1;
          ram_dout     <= mem[ram_ra];
        end
      endcase
    end
  end

  // Bus monitor: every command word the RAM is offered
  logic [9:0] cmd_q [$];
  always @(negedge clk) if (ram_rx_valid === 1'b1) cmd_q.push_back(ram_din);

  // Transaction-level model
  bit         act [2];
  logic       m_we [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_wd [2];
  logic [7:0] shadow [256];
  int         last_w = 1;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic post(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    act[i]    = 1'b1;
    m_we[i]   = w;
    m_addr[i] = a;
    m_wd[i]   = d;
    req[i]    = 1'b1;
    we[i]     = w;
    addr[i*8 +: 8]  = a;
    wdata[i*8 +: 8] = d;
  endtask

  // Waits for the predicted winner's done and checks timing, bus words and results
  task automatic serve();
    int         w;
    int         lat;
    int         n;
    bit         tmo;
    logic [1:0] oh;
    logic [9:0] c0;
    logic [9:0] c1;
    logic [7:0] exp_rd;
    w      = (act[0] && act[1]) ? 1 - last_w : (act[0] ? 0 : 1);
    tmo    = withhold && !m_we[w];
    lat    = m_we[w] ? 3 : (tmo ? 18 : 4);
    oh     = (w == 0) ? 2'b01 : 2'b10;
    c0     = {(m_we[w] ? 2'b00 : 2'b10), m_addr[w]};
    c1     = m_we[w] ? {2'b01, m_wd[w]} : 10'h300;
    exp_rd = m_we[w] ? last_rd : (tmo ? 8'h00 : shadow[m_addr[w]]);
    cmd_q.delete();
    n = 0;
    while (done == 2'b00 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        // winner's inputs change after grant; the bus must keep the latched values
        we[w]           = 1'($urandom);
        addr[w*8 +: 8]  = 8'($urandom);
        wdata[w*8 +: 8] = 8'($urandom);
      end
    end
    check("latency", n, lat);
    check("done", {30'd0, done}, {30'd0, oh});
    check("err", {30'd0, err}, tmo ? {30'd0, oh} : 32'd0);
    check("rdata", {24'd0, rdata}, {24'd0, exp_rd});
    check("ncmd", cmd_q.size(), 2);
    if (cmd_q.size() == 2) begin
      check("cmd_addr", {22'd0, cmd_q[0]}, {22'd0, c0});
      check("cmd_data", {22'd0, cmd_q[1]}, {22'd0, c1});
    end
    if (m_we[w]) shadow[m_addr[w]] = m_wd[w];
    last_rd = exp_rd;
    last_w  = w;
    act[w]  = 1'b0;
    req[w]  = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", {30'd0, done}, 32'd0);
    check("err_clr", {30'd0, err}, 32'd0);
    check("rd_hold", {24'd0, rdata}, {24'd0, last_rd});
    check("ncmd_after", cmd_q.size(), 2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    last_w  = 1;
    last_rd = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    act[0] = 1'b0; act[1] = 1'b0;
    rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = 16'h0; wdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_din", {22'd0, ram_din}, 32'd0);
    check("rst_rxv", {31'd0, ram_rx_valid}, 32'd0);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_err", {30'd0, err}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    rst_n = 1'b1;

    // Single master write then read back
    post(0, 1'b1, 8'h3C, 8'hA5); serve();
    post(0, 1'b0, 8'h3C, 8'h00); serve();

    // Simultaneous requests straight out of reset: A first, then B
    do_reset();
    post(0, 1'b1, 8'h10, 8'h11); post(1, 1'b1, 8'h20, 8'h22); serve(); serve();
    post(0, 1'b0, 8'h10, 8'h00); post(1, 1'b0, 8'h20, 8'h00); serve(); serve();

    // Both masters keep requesting: grants alternate
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) if (!act[i]) post(i, 1'b1, 8'(8'h40 + k), 8'($urandom));
      serve();
    end
    while (act[0] || act[1]) serve();

    // Reset during DATA of a write: outputs clear at once, reissue completes normally
    post(0, 1'b1, 8'h55, 8'h66);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_din", {22'd0, ram_din}, 32'd0);
    check("mid_rst_rxv", {31'd0, ram_rx_valid}, 32'd0);
    check("mid_rst_done", {30'd0, done}, 32'd0);
    check("mid_rst_rdata", {24'd0, rdata}, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_done2", {30'd0, done}, 32'd0);
    rst_n   = 1'b1;
    last_w  = 1;
    last_rd = 8'h00;
    serve();
    post(1, 1'b0, 8'h55, 8'h00); serve();

`ifdef RAM_ARB_TIMEOUT_EN
    // RAM never answers: read ends with err and zero data, then traffic resumes
    withhold = 1'b1;
    post(0, 1'b0, 8'h3C, 8'h00); serve();
    withhold = 1'b0;
    post(1, 1'b0, 8'h3C, 8'h00); serve();
`endif

    // Random traffic over a small address window so reads hit earlier writes
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && $urandom_range(0, 3) != 0)
          post(i, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom));
      end
      if (!act[0] && !act[1]) post(0, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom));
      serve();
    end
    while (act[0] || act[1]) serve();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Two-requester arbiter and sequencer in front of the single-port 8-bit x 256 command-driven RAM. It accepts whole write or read transactions from two independent masters, for example the SPI slave and a background test/scrub engine. Each transaction is serialised into the RAM's 10-bit command stream: `{opcode[1:0], payload[7:0]}` with `rx_valid`. Read data is returned to the owning master only.

## Interface
- `ADDR_SIZE`, 8: RAM address width; payload width is fixed at 8.
- `TIMEOUT_CYCLES`, 15: read-wait limit; used only with `RAM_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 2: per-requester transaction request; bit 0 = A, bit 1 = B; level, held until `done`.
- `we` in 2: 1 = write, 0 = read; per requester.
- `addr` in 2*ADDR_SIZE: packed addresses; A = [7:0], B = [15:8].
- `wdata` in 16: packed write data, same packing as `addr`.
- `done` out 2: one-cycle completion pulse to the granted requester.
- `err` out 2: read timeout flag, valid with `done`.
- `rdata` out 8: read data, valid with `done` for a read.
- `ram_din` out 10: command to the RAM.
- `ram_rx_valid` out 1: command strobe.
- `ram_dout` in 8: RAM read data.
- `ram_tx_valid` in 1: RAM read-data valid.

## Operation
- RAM opcodes: 00 = write address, 01 = write data, 10 = read address, 11 = read trigger (payload 0).
- FSM states: IDLE, ADDR, DATA, RD_WAIT, DONE.
- IDLE: if any `req` is high, pick a grant by round-robin and go to ADDR. Otherwise stay.
- On grant, latch that requester's `we`, `addr` and `wdata`. Later changes on the requester inputs are ignored.
- Round-robin: `last_grant` register, reset value = B, so A wins the first tie. With both requesting, grant the one that is not `last_grant`. With one requesting, grant it.
- ADDR: `ram_rx_valid` = 1, `ram_din` = {00 or 10, addr}. Next state is DATA.
- DATA: `ram_rx_valid` = 1, `ram_din` = {01, wdata} for a write or {11, 8'h00} for a read. Next state is DONE for a write, RD_WAIT for a read.
- RD_WAIT: `ram_rx_valid` = 0. On `ram_tx_valid`, capture `ram_dout` into `rdata` and go to DONE.
- DONE: `done[grant]` = 1 for exactly one cycle. Update `last_grant`, then go to IDLE.
- `ram_tx_valid` outside RD_WAIT is ignored.
- The requester must drop `req` in the cycle after `done`. A `req` still high in IDLE is treated as a new transaction.
- `rdata` holds its value until the next read completes.
- Reset mid-transaction:
  - Return to IDLE immediately; no `done` is issued.
  - The RAM's internal address registers may hold a partial update.
  - Requesters must reissue the transaction.

## Timing
- All outputs are registered.
- Reset values: `ram_din` = 0, `ram_rx_valid` = 0, `done` = 0, `err` = 0, `rdata` = 0, state = IDLE, `last_grant` = B.
- `ram_rx_valid` is high for exactly two consecutive cycles per transaction (ADDR, DATA). It is never high in any other state.
- Write latency: `req` sampled high at edge 0 → ADDR at cycle 1, DATA at 2, `done` at 3.
- Read latency: against the standard RAM (`tx_valid` one cycle after the trigger), `done` at cycle 4.
- Throughput: a new grant is possible in the IDLE cycle after DONE. Back-to-back writes take 4 cycles each.

## Configuration
- `RAM_ARB_TIMEOUT_EN` defined:
  - RD_WAIT counts cycles.
  - If TIMEOUT_CYCLES cycles pass without `ram_tx_valid`, go to DONE with `err[grant]` = 1 and `rdata` = 0.
  - `ram_tx_valid` arriving in the same cycle the limit is reached wins: normal completion.
- `RAM_ARB_TIMEOUT_EN` undefined:
  - RD_WAIT waits indefinitely.
  - `err` is tied to 0 and no counter is built.

## Structure
- Package `ram_arb_pkg`: state enum, opcode constants (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA), and requester index constants REQ_A/REQ_B.
- Sub-module `ram_arb_rr2`: combinational 2-way round-robin pick from `req` and `last_grant`. It outputs a one-hot grant.
- The top level holds the FSM, the latch registers and the timeout counter.

## Test plan
- A write only (`addr` = 8'h3C, `wdata` = 8'hA5), then A read of 8'h3C:
  - Bus sees {00,3C}, {01,A5}, then `done[0]` at cycle 3.
  - Read sees {10,3C}, {11,00}, then `done[0]` with `rdata` = A5 at cycle 4.
- A and B request simultaneously from reset (A write 8'h10 ← 8'h11, B write 8'h20 ← 8'h22):
  - A is served first, B starts in the IDLE cycle after A's DONE.
  - Reading both addresses returns 11 and 22.
- Both `req` held continuously for 4 transactions: grants alternate A, B, A, B and no requester is starved.
- Requester changes `addr`/`wdata` during ADDR: the RAM bus still shows the values latched at grant.
- With `RAM_ARB_TIMEOUT_EN` and the RAM model withholding `tx_valid`: `done` and `err` assert after 15 RD_WAIT cycles with `rdata` = 0, and the next transaction proceeds normally.
- `rst_n` pulsed low during DATA of a write: all outputs are 0 asynchronously, no `done`, and a reissued write completes in 3 cycles.
